// File: rtl/axi4_lite_write_arbiter_if.sv
// AXI4-Lite write bundle with NUM_MASTERS lanes of handshake signals and packed payloads.
// The downstream slave port uses one lane. The B response code is shared by all lanes.
interface axi4_lite_write_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DEPTH       = 4,
    parameter int DATA_SIZE   = 32
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_SIZE / 8;

    logic [NUM_MASTERS*AW-1:0]        write_address;
    logic [NUM_MASTERS-1:0]           write_address_valid;
    logic [NUM_MASTERS-1:0]           write_address_ready;
    logic [NUM_MASTERS*DATA_SIZE-1:0] write_data;
    logic [NUM_MASTERS*SW-1:0]        write_data_strb;
    logic [NUM_MASTERS-1:0]           write_data_valid;
    logic [NUM_MASTERS-1:0]           write_data_ready;
    logic [1:0]                       write_response;
    logic [NUM_MASTERS-1:0]           write_response_valid;
    logic [NUM_MASTERS-1:0]           write_response_ready;

    modport master (
        output write_address, write_address_valid, write_data, write_data_strb,
               write_data_valid, write_response_ready,
        input  write_address_ready, write_data_ready, write_response, write_response_valid
    );

    modport slave (
        input  write_address, write_address_valid, write_data, write_data_strb,
               write_data_valid, write_response_ready,
        output write_address_ready, write_data_ready, write_response, write_response_valid
    );
endinterface

// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write slave between NUM_MASTERS masters.
// One transaction is in flight at a time. The grant is held from the AW/W handshake to the B handshake.
module axi4_lite_write_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DEPTH       = 4,
    parameter int DATA_SIZE   = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_clk_ni,
    axi4_lite_write_arbiter_if.slave       m_bus,
    axi4_lite_write_arbiter_if.master      s_bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = DATA_SIZE / 8;
    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESPONSE} state_t;

    state_t                 r_state;
    logic [GW-1:0]          r_grant;
    logic [GW-1:0]          r_rr_ptr;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_gnt_oh;
    logic                   w_req_g;
    logic                   w_in_ad;
    logic                   w_in_rsp;
    logic                   w_both_ready;
    logic                   w_hs;
    logic                   w_b_hs;
    logic [GW-1:0]          w_pick;
    logic                   w_any;
    int                     w_idx;

    assign w_req        = m_bus.write_address_valid & m_bus.write_data_valid;
    assign w_gnt_oh     = NUM_MASTERS'(1) << r_grant;
    assign w_req_g      = w_req[r_grant];
    assign w_in_ad      = (r_state == ADDR_DATA);
    assign w_in_rsp     = (r_state == RESPONSE);
    assign w_both_ready = s_bus.write_address_ready[0] && s_bus.write_data_ready[0];
    assign w_hs         = w_in_ad && w_req_g && w_both_ready;
    assign w_b_hs       = w_in_rsp && s_bus.write_response_valid[0] && m_bus.write_response_ready[r_grant];

    // Scan from the highest offset down so the requester nearest rr_ptr is the one that remains.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = 0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            w_idx = (int'(r_rr_ptr) + i) % NUM_MASTERS;
            if (w_req[w_idx]) begin
                w_pick = GW'(w_idx);
                w_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (w_hs) r_state <= RESPONSE;
                end
                RESPONSE: begin
                    if (w_b_hs) begin
                        r_rr_ptr <= (r_grant == GW'(NUM_MASTERS - 1)) ? '0 : r_grant + 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Payload is forced to zero outside ADDR_DATA, so a reset clears it immediately.
    assign s_bus.write_address       = w_in_ad ? m_bus.write_address[r_grant*AW +: AW] : '0;
    assign s_bus.write_data          = w_in_ad ? m_bus.write_data[r_grant*DATA_SIZE +: DATA_SIZE] : '0;
    assign s_bus.write_data_strb     = w_in_ad ? m_bus.write_data_strb[r_grant*SW +: SW] : '0;
    assign s_bus.write_address_valid = w_in_ad && w_req_g;
    assign s_bus.write_data_valid    = w_in_ad && w_req_g;
    assign s_bus.write_response_ready = w_in_rsp && m_bus.write_response_ready[r_grant];

    assign m_bus.write_address_ready  = (w_in_ad && w_both_ready) ? w_gnt_oh : '0;
    assign m_bus.write_data_ready     = (w_in_ad && w_both_ready) ? w_gnt_oh : '0;
    assign m_bus.write_response_valid = (w_in_rsp && s_bus.write_response_valid[0]) ? w_gnt_oh : '0;
    assign m_bus.write_response       = w_in_rsp ? s_bus.write_response : 2'b00;

    assign grant_o = r_grant;
    assign busy_o  = (r_state != IDLE);

    a_grant_holds_valid: assert property (@(posedge clk_i) disable iff (!rst_clk_ni)
        w_in_ad |-> w_req_g);
    a_b_only_in_response: assert property (@(posedge clk_i) disable iff (!rst_clk_ni)
        s_bus.write_response_valid[0] |-> w_in_rsp);
    a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_clk_ni)
        (w_in_ad && !w_hs) |=> $stable({s_bus.write_address, s_bus.write_data, s_bus.write_data_strb}));
endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Directed bench: a 2-master arbiter covers the handshake, stall, reset and fairness cases.
// A 4-master arbiter covers the wrap of the round-robin pointer.
module tb_axi4_lite_write_arbiter;
    logic clk;
    logic rst_n;
    logic       grant2;
    logic       busy2;
    logic [1:0] grant4;
    logic       busy4;
    int n_pass;
    int n_total;

    axi4_lite_write_arbiter_if #(.NUM_MASTERS(2), .DEPTH(4), .DATA_SIZE(32)) up2 ();
    axi4_lite_write_arbiter_if #(.NUM_MASTERS(1), .DEPTH(4), .DATA_SIZE(32)) dn2 ();
    axi4_lite_write_arbiter_if #(.NUM_MASTERS(4), .DEPTH(4), .DATA_SIZE(32)) up4 ();
    axi4_lite_write_arbiter_if #(.NUM_MASTERS(1), .DEPTH(4), .DATA_SIZE(32)) dn4 ();

    axi4_lite_write_arbiter #(.NUM_MASTERS(2), .DEPTH(4), .DATA_SIZE(32)) u_dut2 (
        .clk_i(clk), .rst_clk_ni(rst_n), .m_bus(up2.slave), .s_bus(dn2.master),
        .grant_o(grant2), .busy_o(busy2));

    axi4_lite_write_arbiter #(.NUM_MASTERS(4), .DEPTH(4), .DATA_SIZE(32)) u_dut4 (
        .clk_i(clk), .rst_clk_ni(rst_n), .m_bus(up4.slave), .s_bus(dn4.master),
        .grant_o(grant4), .busy_o(busy4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m2(input int k, input logic [1:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic v);
        up2.write_address[k*2 +: 2]   = a;
        up2.write_data[k*32 +: 32]    = d;
        up2.write_data_strb[k*4 +: 4] = s;
        up2.write_address_valid[k]    = v;
        up2.write_data_valid[k]       = v;
    endtask

    task automatic set_m4(input int k, input logic [31:0] d, input logic v);
        up4.write_address[k*2 +: 2]   = 2'(k);
        up4.write_data[k*32 +: 32]    = d;
        up4.write_data_strb[k*4 +: 4] = 4'hF;
        up4.write_address_valid[k]    = v;
        up4.write_data_valid[k]       = v;
    endtask

    // Runs one transaction on the 2-master DUT from IDLE with ready downstream.
    task automatic run_txn2(input int g, input logic [31:0] exp_data, input logic [1:0] code,
                            input bit drop, input string tag);
        settle();
        chk({tag, "_idle_busy"}, 64'(busy2), 64'(0));
        step();
        chk({tag, "_grant"}, 64'(grant2), 64'(g));
        chk({tag, "_dn_awvalid"}, 64'(dn2.write_address_valid), 64'(1));
        chk({tag, "_dn_data"}, 64'(dn2.write_data), 64'(exp_data));
        chk({tag, "_up_awready"}, 64'(up2.write_address_ready), 64'(1) << g);
        step();
        if (drop) set_m2(g, 2'd0, 32'd0, 4'd0, 1'b0);
        dn2.write_response_valid = 1'b1;
        dn2.write_response       = code;
        settle();
        chk({tag, "_up_bvalid"}, 64'(up2.write_response_valid), 64'(1) << g);
        chk({tag, "_up_bresp"}, 64'(up2.write_response), 64'(code));
        step();
        dn2.write_response_valid = 1'b0;
        dn2.write_response       = 2'b00;
        settle();
        chk({tag, "_done_busy"}, 64'(busy2), 64'(0));
    endtask

    task automatic run_txn4(input int g, input logic [31:0] exp_data, input string tag);
        settle();
        chk({tag, "_idle_busy"}, 64'(busy4), 64'(0));
        step();
        chk({tag, "_grant"}, 64'(grant4), 64'(g));
        chk({tag, "_dn_data"}, 64'(dn4.write_data), 64'(exp_data));
        step();
        set_m4(g, 32'd0, 1'b0);
        dn4.write_response_valid = 1'b1;
        settle();
        chk({tag, "_up_bvalid"}, 64'(up4.write_response_valid), 64'(1) << g);
        step();
        dn4.write_response_valid = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        up2.write_address = '0; up2.write_address_valid = '0; up2.write_data = '0;
        up2.write_data_strb = '0; up2.write_data_valid = '0; up2.write_response_ready = 2'b11;
        dn2.write_address_ready = 1'b1; dn2.write_data_ready = 1'b1;
        dn2.write_response = 2'b00; dn2.write_response_valid = 1'b0;
        up4.write_address = '0; up4.write_address_valid = '0; up4.write_data = '0;
        up4.write_data_strb = '0; up4.write_data_valid = '0; up4.write_response_ready = 4'hF;
        dn4.write_address_ready = 1'b1; dn4.write_data_ready = 1'b1;
        dn4.write_response = 2'b00; dn4.write_response_valid = 1'b0;
        step();
        step();
        chk("rst_busy", 64'(busy2), 64'(0));
        chk("rst_grant", 64'(grant2), 64'(0));
        chk("rst_dn_awvalid", 64'(dn2.write_address_valid), 64'(0));
        chk("rst_up_awready", 64'(up2.write_address_ready), 64'(0));
        rst_n = 1'b1;
        step();

        // Single request from m0
        set_m2(0, 2'd0, 32'hDEADBEEF, 4'hF, 1'b1);
        settle();
        chk("t1_latency_dn_valid", 64'(dn2.write_data_valid), 64'(0));
        step();
        chk("t1_dn_strb", 64'(dn2.write_data_strb), 64'hF);
        chk("t1_dn_addr", 64'(dn2.write_address), 64'(0));
        chk("t1_dn_data", 64'(dn2.write_data), 64'hDEADBEEF);
        step();
        set_m2(0, 2'd0, 32'd0, 4'd0, 1'b0);
        dn2.write_response_valid = 1'b1;
        settle();
        chk("t1_up_bvalid", 64'(up2.write_response_valid), 64'b01);
        chk("t1_up_bresp", 64'(up2.write_response), 64'(0));
        step();
        dn2.write_response_valid = 1'b0;
        settle();
        chk("t1_done_busy", 64'(busy2), 64'(0));

        // Both masters request continuously from a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_m2(0, 2'd1, 32'h11111111, 4'hF, 1'b1);
        set_m2(1, 2'd3, 32'h22222222, 4'hC, 1'b1);
        run_txn2(0, 32'h11111111, 2'b00, 1'b0, "t2_a");
        run_txn2(1, 32'h22222222, 2'b00, 1'b0, "t2_b");
        run_txn2(0, 32'h11111111, 2'b00, 1'b0, "t2_c");
        run_txn2(1, 32'h22222222, 2'b00, 1'b0, "t2_d");
        set_m2(1, 2'd0, 32'd0, 4'd0, 1'b0);

        // Downstream stalls for 5 cycles while m1 also requests
        dn2.write_address_ready = 1'b0;
        dn2.write_data_ready    = 1'b0;
        set_m2(0, 2'd2, 32'h12345678, 4'h3, 1'b1);
        step();
        set_m2(1, 2'd1, 32'hCAFEF00D, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t4_dn_data", 64'(dn2.write_data), 64'h12345678);
            chk("t4_up_awready", 64'(up2.write_address_ready), 64'(0));
            chk("t4_grant", 64'(grant2), 64'(0));
            step();
        end
        dn2.write_address_ready = 1'b1;
        dn2.write_data_ready    = 1'b1;
        settle();
        chk("t4_up_wready", 64'(up2.write_data_ready), 64'b01);
        chk("t4_dn_strb", 64'(dn2.write_data_strb), 64'h3);
        step();
        set_m2(0, 2'd0, 32'd0, 4'd0, 1'b0);
        dn2.write_response_valid = 1'b1;
        settle();
        chk("t4_up_bvalid", 64'(up2.write_response_valid), 64'b01);
        step();
        dn2.write_response_valid = 1'b0;
        settle();
        chk("t4_done_busy", 64'(busy2), 64'(0));

        // m1 was waiting; it is granted now and then stalls the B channel for 3 cycles
        step();
        chk("t5_grant", 64'(grant2), 64'(1));
        chk("t5_dn_data", 64'(dn2.write_data), 64'hCAFEF00D);
        step();
        set_m2(1, 2'd0, 32'd0, 4'd0, 1'b0);
        up2.write_response_ready = 2'b00;
        dn2.write_response_valid = 1'b1;
        dn2.write_response       = 2'b10;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t5_dn_bready", 64'(dn2.write_response_ready), 64'(0));
            chk("t5_busy", 64'(busy2), 64'(1));
            chk("t5_up_bvalid", 64'(up2.write_response_valid), 64'b10);
            step();
        end
        up2.write_response_ready = 2'b11;
        settle();
        chk("t5_dn_bready_hs", 64'(dn2.write_response_ready), 64'(1));
        chk("t5_up_bresp", 64'(up2.write_response), 64'b10);
        step();
        dn2.write_response_valid = 1'b0;
        dn2.write_response       = 2'b00;
        settle();
        chk("t5_done_busy", 64'(busy2), 64'(0));

        // m2 is served first so that rr_ptr becomes 3; then m3 wins over m1 and the pointer wraps
        set_m4(2, 32'h22220000, 1'b1);
        run_txn4(2, 32'h22220000, "t3_m2");
        set_m4(1, 32'h11110000, 1'b1);
        set_m4(3, 32'h33330000, 1'b1);
        run_txn4(3, 32'h33330000, "t3_m3");
        run_txn4(1, 32'h11110000, "t3_m1");

        // Reset asserted while in ADDR_DATA
        dn2.write_address_ready = 1'b0;
        dn2.write_data_ready    = 1'b0;
        set_m2(1, 2'd3, 32'h0BADF00D, 4'hF, 1'b1);
        step();
        chk("t6a_grant_before", 64'(grant2), 64'(1));
        dn2.write_address_ready = 1'b1;
        dn2.write_data_ready    = 1'b1;
        rst_n = 1'b0;
        settle();
        chk("t6a_busy", 64'(busy2), 64'(0));
        chk("t6a_grant", 64'(grant2), 64'(0));
        chk("t6a_dn_awvalid", 64'(dn2.write_address_valid), 64'(0));
        chk("t6a_dn_data", 64'(dn2.write_data), 64'(0));
        chk("t6a_up_awready", 64'(up2.write_address_ready), 64'(0));
        set_m2(1, 2'd0, 32'd0, 4'd0, 1'b0);
        step();
        rst_n = 1'b1;
        set_m2(0, 2'd1, 32'hA5A5A5A5, 4'hF, 1'b1);
        run_txn2(0, 32'hA5A5A5A5, 2'b00, 1'b1, "t6_m0");

        // Reset asserted while in RESPONSE (rr_ptr is 1 at this point)
        set_m2(1, 2'd2, 32'h5A5A5A5A, 4'hF, 1'b1);
        step();
        chk("t6b_grant_before", 64'(grant2), 64'(1));
        step();
        set_m2(1, 2'd0, 32'd0, 4'd0, 1'b0);
        dn2.write_response_valid = 1'b1;
        dn2.write_response       = 2'b11;
        settle();
        chk("t6b_up_bvalid_before", 64'(up2.write_response_valid), 64'b10);
        rst_n = 1'b0;
        settle();
        chk("t6b_up_bvalid", 64'(up2.write_response_valid), 64'(0));
        chk("t6b_up_bresp", 64'(up2.write_response), 64'(0));
        chk("t6b_dn_bready", 64'(dn2.write_response_ready), 64'(0));
        chk("t6b_busy", 64'(busy2), 64'(0));
        chk("t6b_grant", 64'(grant2), 64'(0));
        dn2.write_response_valid = 1'b0;
        dn2.write_response       = 2'b00;
        step();
        rst_n = 1'b1;
        set_m2(0, 2'd1, 32'h77777777, 4'hF, 1'b1);
        set_m2(1, 2'd2, 32'h88888888, 4'hF, 1'b1);
        run_txn2(0, 32'h77777777, 2'b00, 1'b1, "t6_restart");
        set_m2(1, 2'd0, 32'd0, 4'd0, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
